// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester, shared-multiplier and result-channel signals for mul_share_arbiter.
// Result channel: a result transfers on every rising edge where res_valid && res_ready; once raised, res_valid/res_id/res_data hold until that edge.
interface mul_share_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] op_a;
  logic [NREQ*N-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [2*N-1:0]    mul_y;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [2*N-1:0]    res_data;
  logic              res_ready;
  logic              busy;

  // Arbiter side
  modport slave (
    input  req, op_a, op_b, mul_y, res_ready,
    output gnt, mul_a, mul_b, res_valid, res_id, res_data, busy
  );

  // Environment side: requesters, multiplier and result consumer
  modport master (
    output req, op_a, op_b, mul_y, res_ready,
    input  gnt, mul_a, mul_b, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational signed multiplier among NREQ requesters;
// operands are registered onto the multiplier, held SETTLE cycles, and the product is returned on a valid/ready channel.
module mul_share_arbiter #(
  parameter int N      = 4,
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  parameter int IDW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mul_share_arbiter_if.slave     bus,
  output logic [1:0]             state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [2*N-1:0] res_data_q, res_data_d;

  logic [N-1:0]   a_slice [NREQ];
  logic [N-1:0]   b_slice [NREQ];
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] scan_idx;
  int             scan_i;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_slice[g] = bus.op_a[g*N +: N];
    assign b_slice[g] = bus.op_b[g*N +: N];
  end

  // First requester at or above the round-robin pointer, wrapping at NREQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_i     = 0;
    scan_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_i = int'(rr_q) + k;
      if (scan_i >= NREQ) scan_i = scan_i - NREQ;
      scan_idx = IDW'(scan_i);
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (state_q == S_IDLE && pick_found) bus.gnt[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          mul_a_d  = a_slice[pick_idx];
          mul_b_d  = b_slice[pick_idx];
          res_id_d = pick_idx;
          cnt_d    = 4'(SETTLE - 1);
          rr_d     = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter starts at SETTLE-1, so the product is sampled on the SETTLE-th WAIT cycle
        if (cnt_q == 4'd0) begin
          res_data_d  = bus.mul_y;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign state_o       = state_q;

endmodule
